eeprom_burst_ctrl: RTL and testbench
====================================

Name: eeprom_burst_ctrl

Overview:
Command sequencer that sits directly upstream of eeprom_basic and drives its request interface. It accepts burst read/write commands from the host and buffers write bytes in an internal FIFO. Write bursts are split at EEPROM page boundaries, read bytes are returned as a pulse stream, and a stuck device raises an error and resets the core.

Parameters:
PAGE_SIZE, 64, EEPROM page size in bytes (power of 2)
FIFO_DEPTH, 64, write FIFO entries (power of 2, >= PAGE_SIZE)
TIMEOUT, 200000, clk cycles allowed between core byte events before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_read  in  1  1: read burst, 0: write burst
cmd_addr  in  16  start word address
cmd_len  in  8  burst length minus 1 (0 = 1 byte, 255 = 256 bytes)
wr_data  in  8  write byte into FIFO
wr_valid  in  1  push wr_data
wr_ready  out  1  FIFO not full
rd_data  out  8  read byte
rd_valid  out  1  one-cycle pulse per read byte
done  out  1  one-cycle pulse at command completion
err  out  1  sticky timeout flag, cleared on next accepted command
core_rw_continue  out  1  to eeprom_basic rw_continue
core_rw_flag  out  1  to eepromrw_flag (1 = read)
core_addr  out  16  to eeprom_addr
core_wrdata  out  8  to wrdata
core_rst_n  out  1  registered reset to eeprom_basic, active low
core_work_ready  in  1  from work_ready
core_data_seq  in  1  from data_seq_out (one pulse per byte)
core_rddata  in  8  from rddata

Behaviour:
- Reset values: cmd_ready=1, wr_ready=1, rd_valid=0, done=0, err=0, core_rw_continue=0, core_rw_flag=0, core_addr=0, core_wrdata=0, core_rst_n=1. Reset flushes the FIFO and puts the FSM in IDLE.
- FIFO: synchronous, push on wr_valid&wr_ready, pop on core_data_seq during a write XFER. Push and pop in the same cycle leave the count unchanged. Push when full is ignored.
- Internal registers: addr (16b, wraps 0xFFFF->0x0000), remaining (9b), chunk (9b, bytes in current transaction), left (9b, bytes left in chunk).
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch cmd_read, addr=cmd_addr, remaining=cmd_len+1, clear err, go to PLAN. cmd_ready=0 in all other states.
  - PLAN (1 cycle): read gives chunk=remaining. Write gives chunk=min(remaining, PAGE_SIZE - addr mod PAGE_SIZE). left=chunk. core_addr=addr, core_rw_flag=cmd_read. Read goes to START; write goes to WAIT_DATA.
  - WAIT_DATA: wait until FIFO count >= chunk, then go to START. No timeout here.
  - START: core_rw_continue=1, core_wrdata=FIFO head. Leave for XFER on the first cycle core_work_ready=0.
  - XFER: core_rw_continue = (left > 1), registered. core_wrdata = FIFO head.
    - On core_data_seq: left--, addr++, remaining--.
    - Read: also capture core_rddata, rd_valid=1 next cycle.
    - On the pulse that takes left to 0, go to WAIT_DONE.
  - WAIT_DONE: wait for core_work_ready=1, which includes the core's internal write-cycle wait. Then if remaining=0, pulse done and go to IDLE; else go to PLAN.
  - RECOVER: core_rst_n=0 for exactly 4 cycles, then core_rst_n=1, pulse done, go to IDLE. The FIFO is flushed on entry.
- Timeout: counter cleared on state entry and on each core_data_seq; counts in START, XFER and WAIT_DONE. At TIMEOUT: set err=1 and go to RECOVER. Unfinished bytes are discarded.
- Single-byte chunk: core_rw_continue goes low on entry to XFER, so the core sends one byte and then STOP (write) or NACK (read).
- Chunk of exactly PAGE_SIZE from an aligned address: single transaction, no split.
- A cmd_valid held while busy is not accepted. wr_valid is accepted in any state.

Test Plan:
- Write, addr=0x0010, cmd_len=3, FIFO preloaded A0..A3 -> one transaction; core_wrdata steps A0,A1,A2,A3 on successive core_data_seq; core_rw_continue low after the 3rd pulse; 4 pops; one done.
- Write, addr=0x003E, cmd_len=3, PAGE_SIZE=64 -> two transactions: core_addr 0x003E with 2 bytes, then 0x0040 with 2 bytes; done only after the second core_work_ready rise.
- Read, addr=0x0100, cmd_len=2, model returns 11,22,33 -> rd_valid pulses with 11,22,33; core_rw_continue 1,1,0 across bytes; done after core_work_ready=1.
- Read, addr=0xFFFF, cmd_len=1 -> single 2-byte transaction; internal addr wraps to 0x0001 at done.
- Write, cmd_len=3 with only 2 bytes in FIFO -> stays in WAIT_DATA, no core_rw_continue; pushing 2 more bytes starts the transfer.
- Core model never pulses core_data_seq, TIMEOUT=100 -> err=1 at cycle 100 of XFER; core_rst_n low 4 cycles; done pulse; FIFO empty; cmd_ready=1; next accepted command clears err.

Source files
------------

// File: rtl/eeprom_burst_ctrl.sv
// eeprom_burst_ctrl: burst command sequencer for eeprom_basic.
// Takes host burst read/write commands, stages write bytes in a FIFO,
// splits write bursts at page boundaries, streams read bytes back, and
// resets the core if it stops producing byte events.
//
// Handshakes: cmd and wr are valid/ready. A transfer happens on a clock
// edge where valid and ready are both high; ready never depends on valid,
// and valid plus its payload must hold steady until that transfer.
// rd_valid and done are single-cycle pulses with no backpressure.
module eeprom_burst_ctrl #(
  parameter int PAGE_SIZE  = 64,
  parameter int FIFO_DEPTH = 64,
  parameter int TIMEOUT    = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic        core_rw_continue,
  output logic        core_rw_flag,
  output logic [15:0] core_addr,
  output logic [7:0]  core_wrdata,
  output logic        core_rst_n,
  input  logic        core_work_ready,
  input  logic        core_data_seq,
  input  logic [7:0]  core_rddata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAN      = 3'd1,
    S_WAIT_DATA = 3'd2,
    S_START     = 3'd3,
    S_XFER      = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_RECOVER   = 3'd6
  } state_t;

  state_t state_q, state_d;

  // Burst bookkeeping
  logic          is_read_q;
  logic [15:0]   addr_q;
  logic [8:0]    remaining_q;
  logic [8:0]    chunk_q;
  logic [8:0]    left_q;
  logic [TW-1:0] tcnt_q;
  logic [1:0]    rcnt_q;

  // Write FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fifo_cnt;

  // Registered outputs
  logic          rd_valid_q, done_q, err_q, core_rw_flag_q, core_rst_n_q;
  logic [7:0]    rd_data_q;
  logic [15:0]   core_addr_q;

  // Combinational helpers
  logic          cmd_fire, xfer_seq, fifo_flush, fifo_full, push, pop;
  logic          timeout_hit, timeout_set, done_set, fifo_enough;
  logic [15:0]   page_off;
  logic [8:0]    page_room, plan_chunk;

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign xfer_seq    = (state_q == S_XFER) && core_data_seq;
  // The FIFO empties on the cycle the FSM commits to RECOVER.
  assign fifo_flush  = (state_d == S_RECOVER) && (state_q != S_RECOVER);
  assign fifo_full   = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign push        = wr_valid && wr_ready;
  assign pop         = xfer_seq && !is_read_q && (fifo_cnt != '0);
  assign timeout_hit = (tcnt_q == TW'(TIMEOUT - 1));
  assign fifo_enough = (32'(fifo_cnt) >= 32'(chunk_q));

  // Bytes left before the next page boundary; a write chunk never crosses it.
  assign page_off    = addr_q & 16'(PAGE_SIZE - 1);
  assign page_room   = 9'(PAGE_SIZE) - page_off[8:0];
  assign plan_chunk  = is_read_q ? remaining_q :
                       ((remaining_q < page_room) ? remaining_q : page_room);

  assign cmd_ready        = (state_q == S_IDLE);
  assign wr_ready         = !fifo_full && !fifo_flush;
  assign core_rw_continue = (state_q == S_START) ||
                            ((state_q == S_XFER) && (left_q > 9'd1));
  assign core_wrdata      = ((state_q == S_START) || (state_q == S_XFER)) ?
                            mem[rd_ptr_q] : 8'h00;
  assign rd_data          = rd_data_q;
  assign rd_valid         = rd_valid_q;
  assign done             = done_q;
  assign err              = err_q;
  assign core_rw_flag     = core_rw_flag_q;
  assign core_addr        = core_addr_q;
  assign core_rst_n       = core_rst_n_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state, done/timeout decisions
  always_comb begin
    state_d     = state_q;
    done_set    = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      S_IDLE:      if (cmd_fire) state_d = S_PLAN;
      S_PLAN:      state_d = is_read_q ? S_START : S_WAIT_DATA;
      S_WAIT_DATA: if (fifo_enough) state_d = S_START;
      S_START: begin
        if (!core_work_ready) state_d = S_XFER;
        else if (timeout_hit) begin
          state_d     = S_RECOVER;
          timeout_set = 1'b1;
        end
      end
      S_XFER: begin
        if (core_data_seq) begin
          if (left_q <= 9'd1) state_d = S_WAIT_DONE;
        end else if (timeout_hit) begin
          state_d     = S_RECOVER;
          timeout_set = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (core_work_ready) begin
          if (remaining_q == 9'd0) begin
            state_d  = S_IDLE;
            done_set = 1'b1;
          end else begin
            state_d = S_PLAN;
          end
        end else if (timeout_hit) begin
          state_d     = S_RECOVER;
          timeout_set = 1'b1;
        end
      end
      S_RECOVER: begin
        if (rcnt_q == 2'd3) begin
          state_d  = S_IDLE;
          done_set = 1'b1;
        end
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Command latch, chunk planning and per-byte address/count stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_read_q   <= 1'b0;
      addr_q      <= 16'h0000;
      remaining_q <= 9'd0;
      chunk_q     <= 9'd0;
      left_q      <= 9'd0;
    end else begin
      if (cmd_fire) begin
        is_read_q   <= cmd_read;
        addr_q      <= cmd_addr;
        remaining_q <= {1'b0, cmd_len} + 9'd1;
      end
      if (state_q == S_PLAN) begin
        chunk_q <= plan_chunk;
        left_q  <= plan_chunk;
      end
      if (xfer_seq) begin
        left_q      <= left_q - 9'd1;
        addr_q      <= addr_q + 16'd1;
        remaining_q <= remaining_q - 9'd1;
      end
    end
  end

  // Stall watchdog: restarts on every state change and every core byte event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
    end else if ((state_d != state_q) || xfer_seq) begin
      tcnt_q <= '0;
    end else if (((state_q == S_START) || (state_q == S_XFER) ||
                  (state_q == S_WAIT_DONE)) && !timeout_hit) begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  // Length of the core reset pulse while in RECOVER
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rcnt_q <= 2'd0;
    else if (state_q == S_RECOVER) rcnt_q <= rcnt_q + 2'd1;
    else                           rcnt_q <= 2'd0;
  end

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fifo_cnt <= '0;
    end else if (fifo_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Registered host and core-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q     <= 1'b0;
      rd_data_q      <= 8'h00;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      core_addr_q    <= 16'h0000;
      core_rw_flag_q <= 1'b0;
      core_rst_n_q   <= 1'b1;
    end else begin
      rd_valid_q <= xfer_seq && is_read_q;
      if (xfer_seq && is_read_q) rd_data_q <= core_rddata;
      done_q <= done_set;
      if (cmd_fire)         err_q <= 1'b0;
      else if (timeout_set) err_q <= 1'b1;
      if (state_q == S_PLAN) begin
        core_addr_q    <= addr_q;
        core_rw_flag_q <= is_read_q;
      end
      core_rst_n_q <= (state_d != S_RECOVER);
    end
  end

endmodule

// File: tb/tb_eeprom_burst_ctrl.sv
// Bench for eeprom_burst_ctrl: behavioural eeprom_basic model, directed
// bursts, expected-value queues popped by monitors.
module tb_eeprom_burst_ctrl;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_read = 1'b0;
  logic [15:0] cmd_addr = 16'h0;
  logic [7:0]  cmd_len = 8'h0;
  logic [7:0]  wr_data = 8'h0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid, done, err;
  logic        core_rw_continue, core_rw_flag, core_rst_n;
  logic [15:0] core_addr;
  logic [7:0]  core_wrdata;
  logic        core_work_ready = 1'b1, core_data_seq = 1'b0;
  logic [7:0]  core_rddata = 8'h0;

  eeprom_burst_ctrl #(.PAGE_SIZE(64), .FIFO_DEPTH(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .core_rw_continue(core_rw_continue), .core_rw_flag(core_rw_flag),
    .core_addr(core_addr), .core_wrdata(core_wrdata), .core_rst_n(core_rst_n),
    .core_work_ready(core_work_ready), .core_data_seq(core_data_seq),
    .core_rddata(core_rddata)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [9:0]  exp_byte_q[$];  // {is_write, rw_continue, wrdata}
  logic [25:0] exp_txn_q[$];   // {core_addr, core_rw_flag, byte count}
  logic [7:0]  exp_rd_q[$];
  logic        exp_done_q[$];  // err level expected at done
  logic [7:0]  rd_src_q[$];    // bytes the core model returns on reads
  int  done_cnt = 0;
  int  txn_cnt = 0;
  bit  model_stuck = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  // Driver: push one byte into the write FIFO (called just after a negedge)
  task automatic push_byte(input logic [7:0] d);
    int n;
    wr_valid = 1'b1;
    wr_data  = d;
    n = 0;
    while (!wr_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("push_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Driver: issue one command and confirm err is cleared by the accept
  task automatic send_cmd(input logic rd, input logic [15:0] a, input logic [7:0] l);
    int n;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_len   = l;
    n = 0;
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("cmd_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("err_clear_on_accept", 32'(err), 32'd0);
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // eeprom_basic behavioural model; compares each byte and transaction
  initial begin : core_model
    logic [15:0] t_addr;
    logic        t_flag, cont, last;
    logic [7:0]  wd;
    logic [9:0]  b;
    logic [25:0] et;
    int          nb, cyc, low;
    forever begin
      @(negedge clk);
      if (rst_n && core_rst_n && core_rw_continue && core_work_ready) begin
        t_addr = core_addr;
        t_flag = core_rw_flag;
        nb = 0;
        core_work_ready = 1'b0;
        txn_cnt++;
        if (model_stuck) begin
          // START->XFER on the next edge; watchdog expires after TO XFER cycles
          cyc = 0;
          while (!err && cyc < 1000) begin @(negedge clk); cyc++; end
          chk("timeout_latency", 32'(cyc), 32'(TO + 1));
          low = 0;
          while (!core_rst_n && low < 50) begin @(negedge clk); low++; end
          chk("core_rst_low_cycles", 32'(low), 32'd4);
          core_work_ready = 1'b1;
        end else begin
          last = 1'b0;
          while (!last && nb < 300) begin
            repeat (2) @(negedge clk);
            cont = core_rw_continue;
            wd   = core_wrdata;
            if (exp_byte_q.size() == 0) begin
              chk("unexpected_byte", 32'd1, 32'd0);
            end else begin
              b = exp_byte_q.pop_front();
              chk("byte_continue", 32'(cont), 32'(b[8]));
              if (b[9]) chk("byte_wrdata", 32'(wd), 32'(b[7:0]));
            end
            core_rddata   = (rd_src_q.size() != 0) ? rd_src_q.pop_front() : 8'hEE;
            core_data_seq = 1'b1;
            @(negedge clk);
            core_data_seq = 1'b0;
            nb++;
            last = !cont;
          end
          if (exp_txn_q.size() == 0) begin
            chk("unexpected_txn", 32'd1, 32'd0);
          end else begin
            et = exp_txn_q.pop_front();
            chk("txn_addr", 32'(t_addr), 32'(et[25:10]));
            chk("txn_flag", 32'(t_flag), 32'(et[9]));
            chk("txn_bytes", 32'(nb), 32'(et[8:0]));
          end
          repeat (5) @(negedge clk);  // core-internal write-cycle wait
          core_work_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: read byte stream and done pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        if (exp_rd_q.size() == 0) chk("unexpected_rd_valid", 32'd1, 32'd0);
        else chk("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          chk("done_err", 32'(err), 32'(exp_done_q.pop_front()));
          chk("done_txns_left", 32'(exp_txn_q.size()), 32'd0);
          chk("done_bytes_left", 32'(exp_byte_q.size()), 32'd0);
        end
        done_cnt++;
      end
    end
  end

  // Watchdog on the whole run
  initial begin
    repeat (30000) @(negedge clk);
    $display("FAIL watchdog actual=running expected=finished");
    errors++;
    summary();
    $finish;
  end

  // Directed stimulus
  initial begin
    int d, t;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_continue", 32'(core_rw_continue), 32'd0);
    chk("rst_flag", 32'(core_rw_flag), 32'd0);
    chk("rst_core_addr", 32'(core_addr), 32'd0);
    chk("rst_core_wrdata", 32'(core_wrdata), 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 4 bytes inside one page
    for (int i = 0; i < 4; i++) push_byte(8'(8'hA0 + i));
    exp_txn_q.push_back({16'h0010, 1'b0, 9'd4});
    for (int i = 0; i < 4; i++) exp_byte_q.push_back({1'b1, 1'(i < 3), 8'(8'hA0 + i)});
    exp_done_q.push_back(1'b0);
    d = done_cnt;
    send_cmd(1'b0, 16'h0010, 8'd3);
    wait_done(d);
    chk("t1_fifo_empty", 32'(dut.fifo_cnt), 32'd0);
    chk("t1_end_addr", 32'(dut.addr_q), 32'h0014);

    // Write crossing a page boundary: 0x3E..0x41 splits 2 + 2
    for (int i = 0; i < 4; i++) push_byte(8'(8'hB0 + i));
    exp_txn_q.push_back({16'h003E, 1'b0, 9'd2});
    exp_txn_q.push_back({16'h0040, 1'b0, 9'd2});
    exp_byte_q.push_back({1'b1, 1'b1, 8'hB0});
    exp_byte_q.push_back({1'b1, 1'b0, 8'hB1});
    exp_byte_q.push_back({1'b1, 1'b1, 8'hB2});
    exp_byte_q.push_back({1'b1, 1'b0, 8'hB3});
    exp_done_q.push_back(1'b0);
    d = done_cnt;
    send_cmd(1'b0, 16'h003E, 8'd3);
    wait_done(d);

    // Read 3 bytes
    rd_src_q = '{8'h11, 8'h22, 8'h33};
    exp_rd_q = '{8'h11, 8'h22, 8'h33};
    exp_txn_q.push_back({16'h0100, 1'b1, 9'd3});
    exp_byte_q.push_back({1'b0, 1'b1, 8'h00});
    exp_byte_q.push_back({1'b0, 1'b1, 8'h00});
    exp_byte_q.push_back({1'b0, 1'b0, 8'h00});
    exp_done_q.push_back(1'b0);
    d = done_cnt;
    send_cmd(1'b1, 16'h0100, 8'd2);
    wait_done(d);

    // Read 2 bytes across the top of the address space
    rd_src_q = '{8'h44, 8'h55};
    exp_rd_q = '{8'h44, 8'h55};
    exp_txn_q.push_back({16'hFFFF, 1'b1, 9'd2});
    exp_byte_q.push_back({1'b0, 1'b1, 8'h00});
    exp_byte_q.push_back({1'b0, 1'b0, 8'h00});
    exp_done_q.push_back(1'b0);
    d = done_cnt;
    send_cmd(1'b1, 16'hFFFF, 8'd1);
    wait_done(d);
    chk("t4_addr_wrap", 32'(dut.addr_q), 32'h0001);

    // Write waits for enough FIFO data
    push_byte(8'hC0);
    push_byte(8'hC1);
    exp_txn_q.push_back({16'h0080, 1'b0, 9'd4});
    for (int i = 0; i < 4; i++) exp_byte_q.push_back({1'b1, 1'(i < 3), 8'(8'hC0 + i)});
    exp_done_q.push_back(1'b0);
    d = done_cnt;
    t = txn_cnt;
    send_cmd(1'b0, 16'h0080, 8'd3);
    repeat (30) @(negedge clk);
    chk("t5_no_txn_start", 32'(txn_cnt), 32'(t));
    chk("t5_no_continue", 32'(core_rw_continue), 32'd0);
    push_byte(8'hC2);
    push_byte(8'hC3);
    wait_done(d);

    // Stuck core: timeout, core reset, FIFO flush
    model_stuck = 1'b1;
    push_byte(8'hD0);
    push_byte(8'hD1);
    push_byte(8'hD2);
    exp_done_q.push_back(1'b1);
    d = done_cnt;
    send_cmd(1'b0, 16'h0200, 8'd0);
    wait_done(d);
    chk("t6_fifo_flushed", 32'(dut.fifo_cnt), 32'd0);
    chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t6_err_sticky", 32'(err), 32'd1);
    chk("t6_core_rst_n", 32'(core_rst_n), 32'd1);
    model_stuck = 1'b0;

    // Next command clears err and runs normally
    push_byte(8'hE0);
    exp_txn_q.push_back({16'h0000, 1'b0, 9'd1});
    exp_byte_q.push_back({1'b1, 1'b0, 8'hE0});
    exp_done_q.push_back(1'b0);
    d = done_cnt;
    send_cmd(1'b0, 16'h0000, 8'd0);
    wait_done(d);
    chk("t7_err_low", 32'(err), 32'd0);

    repeat (10) @(negedge clk);
    chk("end_txn_q_empty", 32'(exp_txn_q.size()), 32'd0);
    chk("end_rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
    chk("end_done_q_empty", 32'(exp_done_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
